// File: rtl/video_timing_rx.sv
// video_timing_rx: measures an incoming hs/vs/de raster, locks onto the expected format and forwards active pixels with x/y coordinates
module video_timing_rx #(
  parameter int H_TOTAL     = 1650,
  parameter int H_DISP      = 1280,
  parameter int V_TOTAL     = 750,
  parameter int V_DISP      = 720,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic        video_hs,
  input  logic        video_vs,
  input  logic        video_de,
  input  logic [23:0] video_rgb,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        frame_start,
  output logic [10:0] meas_h_total,
  output logic [10:0] meas_h_active,
  output logic [10:0] meas_v_total,
  output logic [10:0] meas_v_active,
  output logic        locked,
  output logic        fmt_err
);
  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
  localparam logic [10:0] MAX = '1;
  state_t state;
  logic hs_d, vs_d, de_d, hs_p, vs_p, de_p;
  logic [23:0] rgb_d;
  logic [10:0] h_cnt, x_cnt, v_cnt, y_cnt, h_len, v_len, x_cur;
  logic [3:0] match_cnt, match_nxt;
  logic mm, hs_fall, vs_fall, de_rise, de_fall, line_bad, frame_bad, timeout, vis;
  function automatic logic [10:0] inc(input logic [10:0] v);
    return v == MAX ? v : v + 11'd1;
  endfunction
  // edge detection and per-cycle decisions on the stage-1 samples
  always_comb begin
    hs_fall   = hs_p & ~hs_d;
    vs_fall   = vs_p & ~vs_d;
    de_rise   = ~de_p & de_d;
    de_fall   = de_p & ~de_d;
    h_len     = inc(h_cnt);
    v_len     = hs_fall ? inc(v_cnt) : v_cnt;
    x_cur     = de_rise ? 11'd0 : x_cnt;
    line_bad  = (hs_fall & (h_len != 11'(H_TOTAL))) | (de_fall & (x_cnt != 11'(H_DISP)));
    frame_bad = mm | line_bad | (v_len != 11'(V_TOTAL)) | (y_cnt != 11'(V_DISP));
    timeout   = h_cnt == MAX;
    match_nxt = match_cnt + 4'd1;
    vis       = de_d & locked;
  end
  // stage 1: input capture plus one cycle of history for edge detection
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      {hs_d, vs_d, de_d, hs_p, vs_p, de_p} <= '0;
      rgb_d <= '0;
    end else begin
      {hs_d, vs_d, de_d} <= {video_hs, video_vs, video_de};
      {hs_p, vs_p, de_p} <= {hs_d, vs_d, de_d};
      rgb_d <= video_rgb;
    end
  end
  // saturating raster counters and the measurements they produce
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      {h_cnt, x_cnt, v_cnt, y_cnt} <= '0;
      {meas_h_total, meas_h_active, meas_v_total, meas_v_active} <= '0;
      mm <= 1'b0;
    end else begin
      h_cnt <= hs_fall ? 11'd0 : inc(h_cnt);
      if (hs_fall) meas_h_total <= h_len;
      if (de_d) x_cnt <= inc(x_cur);
      if (de_fall) meas_h_active <= x_cnt;
      v_cnt <= vs_fall ? 11'd0 : hs_fall ? inc(v_cnt) : v_cnt;
      y_cnt <= vs_fall ? 11'd0 : de_fall ? inc(y_cnt) : y_cnt;
      if (vs_fall) begin
        meas_v_total  <= v_len;
        meas_v_active <= y_cnt;
      end
      mm <= vs_fall ? 1'b0 : mm | line_bad;
    end
  end
  // stage 2: pixel forwarding, gated by lock
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      pixel_valid <= 1'b0;
      pixel_data  <= '0;
      pixel_xpos  <= '0;
      pixel_ypos  <= '0;
      frame_start <= 1'b0;
    end else begin
      pixel_valid <= vis;
      pixel_data  <= vis ? rgb_d : 24'd0;
      pixel_xpos  <= vis ? x_cur : 11'd0;
      pixel_ypos  <= vis ? y_cnt : 11'd0;
      frame_start <= vis & (x_cur == 11'd0) & (y_cnt == 11'd0);
    end
  end
  // lock state machine, frames evaluated at each vsync fall
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      state     <= SEARCH;
      match_cnt <= '0;
      locked    <= 1'b0;
      fmt_err   <= 1'b0;
    end else begin
      fmt_err <= 1'b0;
      if (timeout) begin
        state     <= SEARCH;
        match_cnt <= '0;
        locked    <= 1'b0;
      end else if (vs_fall) begin
        case (state)
          SEARCH: begin
            state     <= TRACK;
            match_cnt <= '0;
          end
          TRACK: begin
            if (frame_bad) begin
              match_cnt <= '0;
              fmt_err   <= 1'b1;
            end else begin
              match_cnt <= match_nxt;
              if (match_nxt == 4'(LOCK_FRAMES)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
          end
          LOCKED: begin
            if (frame_bad) begin
              state     <= TRACK;
              match_cnt <= '0;
              locked    <= 1'b0;
              fmt_err   <= 1'b1;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end
endmodule
